// File: rtl/bank_htu_miss_ctrl.sv
// Purpose : sequences the memory traffic implied by one HTU lookup result
//           (dirty-victim writeback, sub-block refill, flush writeback) and
//           keeps saturating read/write hit and miss counters.
// Latency : a request without traffic completes one cycle after accept;
//           each memory step adds handshake plus response wait.
// Backpr. : htu_rdy is high only in IDLE; the memory request holds a stable
//           payload until mem_req_rdy_i.
// Ports   : htu_* capture one lookup result; mem_req_* issue one request at
//           a time; mem_rsp_vld_i completes it; done_* pulse at completion;
//           hit_cnt_o/miss_cnt_o are performance counters.
module bank_htu_miss_ctrl #(
    parameter int SET_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             htu_vld_i,
    output logic             htu_rdy_o,
    input  logic             op_is_read_i,
    input  logic             op_is_write_i,
    input  logic             op_is_flush_i,
    input  logic             op_is_invalidate_i,
    input  logic             cacheline_hit_i,
    input  logic [2:0]       access_way_i,
    input  logic             access_offset_i,
    input  logic [1:0]       offset0_state_i,
    input  logic [1:0]       offset1_state_i,
    input  logic [21:0]      access_tag_i,
    input  logic [21:0]      victim_tag_i,
    input  logic [SET_W-1:0] set_idx_i,
    output logic             mem_req_vld_o,
    input  logic             mem_req_rdy_i,
    output logic             mem_req_is_wb_o,
    output logic [21:0]      mem_req_tag_o,
    output logic [SET_W-1:0] mem_req_set_o,
    output logic [2:0]       mem_req_way_o,
    output logic             mem_req_offset_o,
    input  logic             mem_rsp_vld_i,
    output logic             done_vld_o,
    output logic [2:0]       done_way_o,
    output logic             done_refill_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB0,
        S_WB0_WAIT,
        S_WB1,
        S_WB1_WAIT,
        S_REFILL,
        S_REFILL_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] ST_CLEAN = 2'b01;
    localparam logic [1:0] ST_DIRTY = 2'b10;

    state_t           state_q, state_d;
    logic             accept;

    // Plan of the incoming result; registered at accept so the sequence only
    // ever depends on captured fields.
    logic             in_rw;
    logic [1:0]       in_acc_state;
    logic             in_acc_valid;
    logic             in_wb0, in_wb1, in_refill;

    logic             wb0_q, wb1_q, refill_q;
    logic [2:0]       way_q;
    logic             offset_q;
    logic [21:0]      acc_tag_q;
    logic [21:0]      wb_tag_q;
    logic [SET_W-1:0] set_q;
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

    // Invalidate needs no traffic; it is covered by the default (empty) plan.
    logic             unused_invalidate;
    assign unused_invalidate = op_is_invalidate_i;

    assign accept = htu_vld_i && (state_q == S_IDLE);

    always_comb begin
        in_rw        = op_is_read_i | op_is_write_i;
        in_acc_state = access_offset_i ? offset1_state_i : offset0_state_i;
        // 11 is not a legal state and counts as INVALID
        in_acc_valid = (in_acc_state == ST_CLEAN) || (in_acc_state == ST_DIRTY);
        in_wb0       = 1'b0;
        in_wb1       = 1'b0;
        in_refill    = 1'b0;
        if (in_rw) begin
            if (cacheline_hit_i) begin
                in_refill = !in_acc_valid;
            end else begin
                in_wb0    = (offset0_state_i == ST_DIRTY);
                in_wb1    = (offset1_state_i == ST_DIRTY);
                in_refill = 1'b1;
            end
        end else if (op_is_flush_i && cacheline_hit_i) begin
            in_wb0 = (offset0_state_i == ST_DIRTY);
            in_wb1 = (offset1_state_i == ST_DIRTY);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wb0_q      <= 1'b0;
            wb1_q      <= 1'b0;
            refill_q   <= 1'b0;
            way_q      <= '0;
            offset_q   <= 1'b0;
            acc_tag_q  <= '0;
            wb_tag_q   <= '0;
            set_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wb0_q     <= in_wb0;
                wb1_q     <= in_wb1;
                refill_q  <= in_refill;
                way_q     <= access_way_i;
                offset_q  <= access_offset_i;
                acc_tag_q <= access_tag_i;
                // A flush writes back the hit line; a miss writes back the victim.
                wb_tag_q  <= cacheline_hit_i ? access_tag_i : victim_tag_i;
                set_q     <= set_idx_i;
                if (in_rw && cacheline_hit_i && (hit_cnt_q != '1)) begin
                    hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                end
                if (in_rw && !cacheline_hit_i && (miss_cnt_q != '1)) begin
                    miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_wb0)         state_d = S_WB0;
                    else if (in_wb1)    state_d = S_WB1;
                    else if (in_refill) state_d = S_REFILL;
                    else                state_d = S_DONE;
                end
            end
            S_WB0:      if (mem_req_rdy_i) state_d = S_WB0_WAIT;
            S_WB0_WAIT: begin
                if (mem_rsp_vld_i) begin
                    if (wb1_q)         state_d = S_WB1;
                    else if (refill_q) state_d = S_REFILL;
                    else               state_d = S_DONE;
                end
            end
            S_WB1:      if (mem_req_rdy_i) state_d = S_WB1_WAIT;
            S_WB1_WAIT: begin
                if (mem_rsp_vld_i) state_d = refill_q ? S_REFILL : S_DONE;
            end
            S_REFILL:      if (mem_req_rdy_i) state_d = S_REFILL_WAIT;
            S_REFILL_WAIT: if (mem_rsp_vld_i) state_d = S_DONE;
            S_DONE:        state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // Outputs are zeroed outside their valid window so idle payload is quiet.
    always_comb begin
        htu_rdy_o        = (state_q == S_IDLE);
        mem_req_vld_o    = (state_q == S_WB0) || (state_q == S_WB1) ||
                           (state_q == S_REFILL);
        mem_req_is_wb_o  = (state_q == S_WB0) || (state_q == S_WB1);
        mem_req_tag_o    = '0;
        mem_req_set_o    = '0;
        mem_req_way_o    = '0;
        mem_req_offset_o = 1'b0;
        if (mem_req_vld_o) begin
            mem_req_tag_o    = (state_q == S_REFILL) ? acc_tag_q : wb_tag_q;
            mem_req_set_o    = set_q;
            mem_req_way_o    = way_q;
            mem_req_offset_o = (state_q == S_REFILL) ? offset_q : (state_q == S_WB1);
        end
        done_vld_o    = (state_q == S_DONE);
        done_way_o    = done_vld_o ? way_q : 3'd0;
        done_refill_o = done_vld_o && refill_q;
        hit_cnt_o     = hit_cnt_q;
        miss_cnt_o    = miss_cnt_q;
    end

endmodule
